// File: rtl/ara_trace_ctrl.sv
// Trace-window controller for Ara's VLSU W channel: capture FSM, 2-entry trace FIFO, saturating stats.
// Optional ARA_TRACE_UNGATED_EN: ignore cnt_en_i for capture and cycle counting.
//
// state   | meaning
// IDLE    | waiting for TriggerOn
// ACTIVE  | window open, beats captured and counted
// STOPPED | window closed by TriggerOff, one-shot
// DONE    | exit seen, terminal until reset
module ara_trace_ctrl #(
  parameter int unsigned AxiDataWidth = 256,
  parameter int unsigned CntWidth     = 64,
  parameter logic [63:0] TriggerOn    = 64'h1,
  parameter logic [63:0] TriggerOff   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [63:0]               trigger_i,
  input  logic                      cnt_en_i,
  input  logic [63:0]               exit_i,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_valid_i,
  input  logic                      w_ready_i,
  output logic [AxiDataWidth-1:0]   trc_data_o,
  output logic [AxiDataWidth/8-1:0] trc_strb_o,
  output logic                      trc_valid_o,
  input  logic                      trc_ready_i,
  output logic [1:0]                state_o,
  output logic [CntWidth-1:0]       cycles_o,
  output logic [CntWidth-1:0]       beats_o,
  output logic [CntWidth-1:0]       bytes_o,
  output logic [CntWidth-1:0]       drops_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [62:0]               exit_code_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    STOPPED = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [62:0]           exit_code_q, exit_code_d;
  logic                  fail_q, fail_d;
  logic [AxiDataWidth-1:0] data_q [2];
  logic [AxiDataWidth-1:0] data_d [2];
  logic [StrbWidth-1:0]  strb_q [2];
  logic [StrbWidth-1:0]  strb_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [CntWidth-1:0]   cycles_q, cycles_d, beats_q, beats_d;
  logic [CntWidth-1:0]   bytes_q, bytes_d, drops_q, drops_d;

  logic cnt_gate, cap, full, pop, push, drop;

`ifdef ARA_TRACE_UNGATED_EN
  assign cnt_gate = 1'b1;
`else
  assign cnt_gate = cnt_en_i;
`endif

  function automatic logic [CntWidth-1:0] popcnt(input logic [StrbWidth-1:0] s);
    logic [CntWidth-1:0] c;
    c = '0;
    for (int i = 0; i < int'(StrbWidth); i++) c = c + CntWidth'(s[i]);
    return c;
  endfunction

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [CntWidth-1:0] b);
    logic [CntWidth:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CntWidth] ? '1 : s[CntWidth-1:0];
  endfunction

  // Registered state: the TriggerOn cycle itself is never captured.
  assign cap  = (state_q == ACTIVE) & cnt_gate & w_valid_i & w_ready_i;
  assign full = (count_q == 2'd2);
  assign pop  = (count_q != 2'd0) & trc_ready_i;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_comb begin
    state_d     = state_q;
    exit_code_d = exit_code_q;
    fail_d      = fail_q;
    if (state_q != DONE && exit_i[0]) begin
      state_d     = DONE;
      exit_code_d = exit_i[63:1];
      fail_d      = |exit_i[63:1];
    end else begin
      unique case (state_q)
        IDLE:    if (trigger_i == TriggerOn)  state_d = ACTIVE;
        ACTIVE:  if (trigger_i == TriggerOff) state_d = STOPPED;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    data_d   = data_q;
    strb_d   = strb_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (push) begin
      data_d[wr_ptr_q] = w_data_i;
      strb_d[wr_ptr_q] = w_strb_i;
    end
    cycles_d = cycles_q;
    beats_d  = beats_q;
    bytes_d  = bytes_q;
    drops_d  = drops_q;
    if (state_q == ACTIVE && cnt_gate) cycles_d = sat_add(cycles_q, CntWidth'(1));
    if (push) begin
      beats_d = sat_add(beats_q, CntWidth'(1));
      bytes_d = sat_add(bytes_q, popcnt(w_strb_i));
    end
    if (drop) drops_d = sat_add(drops_q, CntWidth'(1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      exit_code_q <= '0;
      fail_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      cycles_q    <= '0;
      beats_q     <= '0;
      bytes_q     <= '0;
      drops_q     <= '0;
    end else begin
      state_q     <= state_d;
      exit_code_q <= exit_code_d;
      fail_q      <= fail_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cycles_q    <= cycles_d;
      beats_q     <= beats_d;
      bytes_q     <= bytes_d;
      drops_q     <= drops_d;
    end
  end

  assign trc_data_o  = data_q[rd_ptr_q];
  assign trc_strb_o  = strb_q[rd_ptr_q];
  assign trc_valid_o = (count_q != 2'd0);
  assign state_o     = state_q;
  assign cycles_o    = cycles_q;
  assign beats_o     = beats_q;
  assign bytes_o     = bytes_q;
  assign drops_o     = drops_q;
  assign done_o      = (state_q == DONE);
  assign fail_o      = fail_q;
  assign exit_code_o = exit_code_q;

endmodule

// File: tb/tb_ara_trace_ctrl.sv
// Randomized bench for ara_trace_ctrl against a queue-based reference model.
module tb_ara_trace_ctrl;

  localparam logic [63:0] T_ON  = 64'h1;
  localparam logic [63:0] T_OFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int S_IDLE = 0, S_ACTIVE = 1, S_STOPPED = 2, S_DONE = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [63:0]  trigger_i, exit_i;
  logic         cnt_en_i, w_valid_i, w_ready_i, trc_ready_i;
  logic [255:0] w_data_i, trc_data_o;
  logic [31:0]  w_strb_i, trc_strb_o;
  logic         trc_valid_o, done_o, fail_o;
  logic [1:0]   state_o;
  logic [63:0]  cycles_o, beats_o, bytes_o, drops_o;
  logic [62:0]  exit_code_o;

  ara_trace_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .trigger_i(trigger_i), .cnt_en_i(cnt_en_i),
    .exit_i(exit_i), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .trc_data_o(trc_data_o),
    .trc_strb_o(trc_strb_o), .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i),
    .state_o(state_o), .cycles_o(cycles_o), .beats_o(beats_o), .bytes_o(bytes_o),
    .drops_o(drops_o), .done_o(done_o), .fail_o(fail_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int           m_st;
  logic [255:0] q_data[$];
  logic [31:0]  q_strb[$];
  logic [63:0]  m_cyc, m_beats, m_bytes, m_drops;
  logic         m_fail;
  logic [62:0]  m_code;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 256'(state_o), 256'(m_st));
    chk("valid", 256'(trc_valid_o), 256'(q_data.size() != 0));
    if (q_data.size() != 0) begin
      chk("trc_data", trc_data_o, q_data[0]);
      chk("trc_strb", 256'(trc_strb_o), 256'(q_strb[0]));
    end
    chk("cycles", 256'(cycles_o), 256'(m_cyc));
    chk("beats", 256'(beats_o), 256'(m_beats));
    chk("bytes", 256'(bytes_o), 256'(m_bytes));
    chk("drops", 256'(drops_o), 256'(m_drops));
    chk("done", 256'(done_o), 256'(m_st == S_DONE));
    chk("fail", 256'(fail_o), 256'(m_fail));
    chk("exit_code", 256'(exit_code_o), 256'(m_code));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    trigger_i = '0; exit_i = '0; cnt_en_i = 1'b0; w_valid_i = 1'b0;
    w_ready_i = 1'b0; trc_ready_i = 1'b0; w_data_i = '0; w_strb_i = '0;
    m_st = S_IDLE; q_data.delete(); q_strb.delete();
    m_cyc = '0; m_beats = '0; m_bytes = '0; m_drops = '0; m_fail = 1'b0; m_code = '0;
    #1;
    chk("rst_data", trc_data_o, 256'd0);
    chk("rst_strb", 256'(trc_strb_o), 256'd0);
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input logic [63:0] trig, input logic en, input logic [63:0] ex,
                      input logic wv, input logic wr, input logic rdy, input logic [31:0] strb);
    logic [255:0] d;
    bit pop, cap, gate;
    int sz;
    d = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    trigger_i = trig; cnt_en_i = en; exit_i = ex; w_valid_i = wv; w_ready_i = wr;
    trc_ready_i = rdy; w_data_i = d; w_strb_i = strb;
`ifdef ARA_TRACE_UNGATED_EN
    gate = 1'b1;
`else
    gate = en;
`endif
    sz  = q_data.size();
    pop = (sz > 0) && rdy;
    cap = (m_st == S_ACTIVE) && gate && wv && wr;
    if (m_st == S_ACTIVE && gate) m_cyc++;
    if (pop) begin
      void'(q_data.pop_front());
      void'(q_strb.pop_front());
    end
    if (cap) begin
      if (sz < 2 || pop) begin
        q_data.push_back(d);
        q_strb.push_back(strb);
        m_beats++;
        m_bytes += 64'($countones(strb));
      end else m_drops++;
    end
    if (m_st != S_DONE && ex[0]) begin
      m_st = S_DONE; m_code = ex[63:1]; m_fail = |ex[63:1];
    end else if (m_st == S_IDLE && trig == T_ON) m_st = S_ACTIVE;
    else if (m_st == S_ACTIVE && trig == T_OFF) m_st = S_STOPPED;
    @(negedge clk_i);
    check_all();
  endtask

  logic [63:0] b0, d0, c0;

  initial begin
    rst_i = 1'b1;
    do_reset();

    // 1: open window, three full-strobe beats streamed straight through
    step(T_ON, 1, 0, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 1, 32'hFFFF_FFFF);
    chk("s1_beats", 256'(beats_o), 256'd3);
    chk("s1_bytes", 256'(bytes_o), 256'd96);
    step(0, 1, 0, 0, 0, 1, '0);

    // 2: sink stalled, four beats -> two kept, two dropped, then drain
    b0 = beats_o; d0 = drops_o;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1, 0, $urandom());
    chk("s2_beats", 256'(beats_o - b0), 256'd2);
    chk("s2_drops", 256'(drops_o - d0), 256'd2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, '0);
    chk("s2_drained", 256'(trc_valid_o), 256'd0);

    // 3: counter enable low with beats present
    b0 = beats_o; c0 = cycles_o;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 1, $urandom());
`ifdef ARA_TRACE_UNGATED_EN
    chk("s3_cycles", 256'(cycles_o - c0), 256'd5);
    chk("s3_beats", 256'(beats_o - b0), 256'd5);
`else
    chk("s3_cycles", 256'(cycles_o - c0), 256'd0);
    chk("s3_beats", 256'(beats_o - b0), 256'd0);
`endif

    // 4: TriggerOff beat is captured; re-trigger ignored
    b0 = beats_o;
    step(T_OFF, 1, 0, 1, 1, 1, $urandom());
    chk("s4_state", 256'(state_o), 256'd2);
    chk("s4_beat", 256'(beats_o - b0), 256'd1);
    step(T_ON, 1, 0, 1, 1, 1, $urandom());
    step(0, 1, 0, 1, 1, 1, $urandom());
    chk("s4_stay", 256'(state_o), 256'd2);
    chk("s4_nocap", 256'(beats_o - b0), 256'd1);

    // 5: failing exit, later exit ignored
    do_reset();
    step(T_ON, 1, 0, 0, 0, 1, '0);
    step(0, 1, 64'h7, 1, 1, 1, $urandom());
    chk("s5_state", 256'(state_o), 256'd3);
    chk("s5_done", 256'(done_o), 256'd1);
    chk("s5_fail", 256'(fail_o), 256'd1);
    chk("s5_code", 256'(exit_code_o), 256'd3);
    step(0, 1, 64'h1, 1, 1, 1, $urandom());
    chk("s5_code_kept", 256'(exit_code_o), 256'd3);

    // 6: trigger and passing exit together from IDLE
    do_reset();
    step(T_ON, 1, 64'h1, 1, 1, 1, $urandom());
    chk("s6_state", 256'(state_o), 256'd3);
    chk("s6_fail", 256'(fail_o), 256'd0);
    for (int i = 0; i < 4; i++) step(T_ON, 1, 0, 1, 1, 1, $urandom());
    chk("s6_beats", 256'(beats_o), 256'd0);

    // random rounds, each starting with a reset (also hits reset mid-window)
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        logic [63:0] trig, ex;
        int k;
        k = $urandom_range(0, 99);
        trig = (k < 8) ? T_ON : (k < 12) ? T_OFF : (k < 20) ? {$urandom(), $urandom()} : 64'd0;
        ex = ($urandom_range(0, 199) == 0) ? {$urandom(), $urandom()} | 64'h1 : 64'd0;
        if ($urandom_range(0, 3) == 0) ex = ex & 64'h1;
        step(trig, $urandom_range(0, 9) < 8, ex, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
